// File: rtl/floatmul_result_slice.sv
// rtl/floatmul_result_slice.sv - 2-entry skid-buffered float32 result slice with IEEE-754 classing and counters
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   busy         1 while any beat is held
//   clear        synchronous clear of all statistics counters
//   i_valid      upstream beat valid
//   i_payload    upstream float32 (sign[31] exp[30:23] mant[22:0])
//   i_ready      upstream ready, straight from a state flop
//   o_valid      downstream beat valid, straight from a state flop
//   o_payload    downstream float32, bit-identical to the accepted beat
//   o_class      0 normal, 1 zero, 2 subnormal, 3 inf, 4 nan
//   o_ready      downstream ready
//   cnt_total    accepted beats (saturating)
//   cnt_zero     accepted +/-0
//   cnt_subnorm  accepted subnormals
//   cnt_inf      accepted +/-inf
//   cnt_nan      accepted NaNs (quiet or signalling)

module floatmul_result_slice #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic             clear,
    input  logic             i_valid,
    input  logic [31:0]      i_payload,
    output logic             i_ready,
    output logic             o_valid,
    output logic [31:0]      o_payload,
    output logic [2:0]       o_class,
    input  logic             o_ready,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_zero,
    output logic [CNT_W-1:0] cnt_subnorm,
    output logic [CNT_W-1:0] cnt_inf,
    output logic [CNT_W-1:0] cnt_nan
);

    localparam logic [2:0] CLS_NORMAL  = 3'd0;
    localparam logic [2:0] CLS_ZERO    = 3'd1;
    localparam logic [2:0] CLS_SUBNORM = 3'd2;
    localparam logic [2:0] CLS_INF     = 3'd3;
    localparam logic [2:0] CLS_NAN     = 3'd4;

    // Encoding chosen so bit 0 is "OUT holds a beat" and bit 1 is "SKID
    // holds a beat": o_valid and i_ready are then bare flop outputs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] skid_payload;
    logic [2:0]  skid_class;
    logic [2:0]  in_class;

    logic        accept;
    logic        emit;
    logic        load_out_in;
    logic        load_out_skid;
    logic        load_skid;

    function automatic logic [2:0] classify(input logic [31:0] f);
        logic [7:0]  e;
        logic [22:0] m;
        e = f[30:23];
        m = f[22:0];
        if (e == 8'h00) begin
            classify = (m == 23'd0) ? CLS_ZERO : CLS_SUBNORM;
        end else if (e == 8'hFF) begin
            classify = (m == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            classify = CLS_NORMAL;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_class = classify(i_payload);
    assign o_valid  = state[0];
    assign i_ready  = ~state[1];
    assign busy     = state[0] | state[1];
    assign accept   = i_valid & i_ready;
    assign emit     = o_valid & o_ready;

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_nxt   = ST_HALF;
                end
            end
            ST_HALF: begin
                if (accept && emit) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // i_ready is low here, so only the drain path can fire.
                if (emit) begin
                    load_out_skid = 1'b1;
                    state_nxt     = ST_HALF;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_payload    <= 32'd0;
            o_class      <= CLS_NORMAL;
            skid_payload <= 32'd0;
            skid_class   <= CLS_NORMAL;
        end else begin
            if (load_out_in) begin
                o_payload <= i_payload;
                o_class   <= in_class;
            end else if (load_out_skid) begin
                o_payload <= skid_payload;
                o_class   <= skid_class;
            end
            if (load_skid) begin
                skid_payload <= i_payload;
                skid_class   <= in_class;
            end
        end
    end

    // Clear takes priority over a same-cycle acceptance, so that beat is
    // deliberately left uncounted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_total   <= '0;
            cnt_zero    <= '0;
            cnt_subnorm <= '0;
            cnt_inf     <= '0;
            cnt_nan     <= '0;
        end else if (clear) begin
            cnt_total   <= '0;
            cnt_zero    <= '0;
            cnt_subnorm <= '0;
            cnt_inf     <= '0;
            cnt_nan     <= '0;
        end else if (accept) begin
            cnt_total <= sat_inc(cnt_total);
            case (in_class)
                CLS_ZERO:    cnt_zero    <= sat_inc(cnt_zero);
                CLS_SUBNORM: cnt_subnorm <= sat_inc(cnt_subnorm);
                CLS_INF:     cnt_inf     <= sat_inc(cnt_inf);
                CLS_NAN:     cnt_nan     <= sat_inc(cnt_nan);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floatmul_result_slice.sv
// tb/tb_floatmul_result_slice.sv - directed and randomized self-checking bench for floatmul_result_slice

module tb_floatmul_result_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        i_valid;
    logic [31:0] i_payload;
    logic        o_ready;

    logic        busy;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_payload;
    logic [2:0]  o_class;
    logic [15:0] cnt_total, cnt_zero, cnt_subnorm, cnt_inf, cnt_nan;

    logic        s_busy;
    logic        s_i_ready;
    logic        s_o_valid;
    logic [31:0] s_o_payload;
    logic [2:0]  s_o_class;
    logic [1:0]  s_cnt_total, s_cnt_zero, s_cnt_subnorm, s_cnt_inf, s_cnt_nan;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    floatmul_result_slice #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .busy(busy), .clear(clear),
        .i_valid(i_valid), .i_payload(i_payload), .i_ready(i_ready),
        .o_valid(o_valid), .o_payload(o_payload), .o_class(o_class), .o_ready(o_ready),
        .cnt_total(cnt_total), .cnt_zero(cnt_zero), .cnt_subnorm(cnt_subnorm),
        .cnt_inf(cnt_inf), .cnt_nan(cnt_nan)
    );

    floatmul_result_slice #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .busy(s_busy), .clear(clear),
        .i_valid(i_valid), .i_payload(i_payload), .i_ready(s_i_ready),
        .o_valid(s_o_valid), .o_payload(s_o_payload), .o_class(s_o_class), .o_ready(o_ready),
        .cnt_total(s_cnt_total), .cnt_zero(s_cnt_zero), .cnt_subnorm(s_cnt_subnorm),
        .cnt_inf(s_cnt_inf), .cnt_nan(s_cnt_nan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] f);
        if (f[30:0] == 31'd0)                          return 3'd1;
        if (f[30:23] == 8'd0)                          return 3'd2;
        if (f[30:23] == 8'd255 && f[22:0] == 23'd0)    return 3'd3;
        if (f[30:23] == 8'd255)                        return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] gen_payload();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: r[30:0]  = 31'd0;
            3: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] cls_vec [6];
    logic [2:0]  cls_exp [6];
    logic [31:0] exp_q [$];
    logic [31:0] head;
    logic        acc, emt;
    int          occ;
    int          acc_n;

    initial begin
        rst = 1'b0; clear = 1'b0; i_valid = 1'b0; i_payload = 32'd0; o_ready = 1'b0;
        #1;

        // reset state
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt_total", 32'(cnt_total), 32'd0);
        chk("rst_o_payload", o_payload, 32'd0);
        chk("rst_o_class", 32'(o_class), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_i_ready", 32'(i_ready), 32'd1);

        // 1: eight normal beats streaming
        o_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_payload = 32'h3F80_0000 + 32'(k) * 32'h0080_0000;
            chk("t1_i_ready", 32'(i_ready), 32'd1);
            tick();
            chk("t1_o_valid", 32'(o_valid), 32'd1);
            chk("t1_o_payload", o_payload, 32'h3F80_0000 + 32'(k) * 32'h0080_0000);
            chk("t1_o_class", 32'(o_class), 32'd0);
        end
        i_valid = 1'b0;
        tick();
        chk("t1_drained", 32'(o_valid), 32'd0);
        chk("t1_cnt_total", 32'(cnt_total), 32'd8);
        chk("t1_cnt_zero", 32'(cnt_zero), 32'd0);
        chk("t1_cnt_nan", 32'(cnt_nan), 32'd0);

        // 2: fill to FULL with o_ready low, then drain
        o_ready = 1'b0;
        i_valid = 1'b1; i_payload = 32'h4049_0FDB;
        tick();
        chk("t2_half_i_ready", 32'(i_ready), 32'd1);
        i_payload = 32'hC020_0000;
        tick();
        i_valid = 1'b0;
        chk("t2_full_i_ready", 32'(i_ready), 32'd0);
        chk("t2_full_busy", 32'(busy), 32'd1);
        chk("t2_hold_payload", o_payload, 32'h4049_0FDB);
        tick();
        chk("t2_still_hold", o_payload, 32'h4049_0FDB);
        o_ready = 1'b1;
        tick();
        chk("t2_second_payload", o_payload, 32'hC020_0000);
        chk("t2_second_valid", 32'(o_valid), 32'd1);
        chk("t2_ready_back", 32'(i_ready), 32'd1);
        tick();
        chk("t2_empty", 32'(o_valid), 32'd0);

        // 3: classification of special values
        clear = 1'b1; tick(); clear = 1'b0;
        cls_vec[0] = 32'h0000_0000; cls_exp[0] = 3'd1;
        cls_vec[1] = 32'h8000_0001; cls_exp[1] = 3'd2;
        cls_vec[2] = 32'h7F80_0000; cls_exp[2] = 3'd3;
        cls_vec[3] = 32'hFF80_0000; cls_exp[3] = 3'd3;
        cls_vec[4] = 32'h7FC0_0000; cls_exp[4] = 3'd4;
        cls_vec[5] = 32'h7F80_0001; cls_exp[5] = 3'd4;
        for (int k = 0; k < 6; k++) begin
            i_valid = 1'b1; i_payload = cls_vec[k];
            tick();
            chk("t3_o_payload", o_payload, cls_vec[k]);
            chk("t3_o_class", 32'(o_class), 32'(cls_exp[k]));
        end
        i_valid = 1'b0;
        tick();
        chk("t3_cnt_zero", 32'(cnt_zero), 32'd1);
        chk("t3_cnt_subnorm", 32'(cnt_subnorm), 32'd1);
        chk("t3_cnt_inf", 32'(cnt_inf), 32'd2);
        chk("t3_cnt_nan", 32'(cnt_nan), 32'd2);
        chk("t3_cnt_total", 32'(cnt_total), 32'd6);

        // 4: saturation on the 2-bit instance, then clear vs. acceptance
        rst = 1'b0; tick(); rst = 1'b1; tick();
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1; i_payload = (k % 2 == 0) ? 32'h0000_0000 : 32'h8000_0000;
            tick();
        end
        chk("t4_sat_zero", 32'(s_cnt_zero), 32'd3);
        chk("t4_sat_total", 32'(s_cnt_total), 32'd3);
        chk("t4_wide_zero", 32'(cnt_zero), 32'd5);
        i_payload = 32'h0000_0000; clear = 1'b1;
        chk("t4_clear_beat_ready", 32'(i_ready), 32'd1);
        tick();
        clear = 1'b0; i_valid = 1'b0;
        chk("t4_clr_s_total", 32'(s_cnt_total), 32'd0);
        chk("t4_clr_s_zero", 32'(s_cnt_zero), 32'd0);
        chk("t4_clr_total", 32'(cnt_total), 32'd0);
        chk("t4_beat_valid", 32'(o_valid), 32'd1);
        chk("t4_beat_class", 32'(o_class), 32'd1);
        tick();
        chk("t4_drained", 32'(o_valid), 32'd0);

        // 5: random handshakes against a queue model
        clear = 1'b1; tick(); clear = 1'b0;
        occ = 0; acc_n = 0; i_valid = 1'b0;
        for (int cyc = 0; cyc < 20000 && acc_n < 1000; cyc++) begin
            if (!i_valid) begin
                i_valid = 1'($urandom_range(0, 1));
                if (i_valid) i_payload = gen_payload();
            end
            o_ready = 1'($urandom_range(0, 1));
            chk("t5_i_ready", 32'(i_ready), 32'(occ < 2));
            chk("t5_o_valid", 32'(o_valid), 32'(occ > 0));
            acc = i_valid & i_ready;
            emt = o_valid & o_ready;
            if (emt && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                chk("t5_payload", o_payload, head);
                chk("t5_class", 32'(o_class), 32'(ref_class(head)));
            end
            if (acc) begin
                exp_q.push_back(i_payload);
                acc_n++;
            end
            tick();
            occ = occ + int'(acc) - int'(emt);
            if (acc) i_valid = 1'b0;
        end
        chk("t5_accepted", 32'(acc_n), 32'd1000);
        i_valid = 1'b0; o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (o_valid && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                chk("t5_drain_payload", o_payload, head);
            end
            tick();
        end
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_out_empty", 32'(o_valid), 32'd0);
        chk("t5_cnt_total", 32'(cnt_total), 32'(acc_n));

        // 6: asynchronous reset while FULL
        o_ready = 1'b0;
        i_valid = 1'b1; i_payload = 32'h4100_0000; tick();
        i_payload = 32'h4110_0000; tick();
        i_valid = 1'b0;
        chk("t6_full", 32'(i_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_o_valid", 32'(o_valid), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_cnt", 32'(cnt_total), 32'd0);
        #1 rst = 1'b1;
        tick();
        chk("t6_ready_after", 32'(i_ready), 32'd1);
        chk("t6_empty_after", 32'(o_valid), 32'd0);
        o_ready = 1'b1; i_valid = 1'b1; i_payload = 32'h4120_0000;
        tick();
        i_valid = 1'b0;
        chk("t6_next_valid", 32'(o_valid), 32'd1);
        chk("t6_next_payload", o_payload, 32'h4120_0000);
        chk("t6_next_cnt", 32'(cnt_total), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
